// File: rtl/cam_pkg.sv
// Shared definitions for the camera stream generator and the cam2ram capture benches:
// pattern encodings, FSM states and the default bus timing.
package cam_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_RAM   = 2'd2,
    PAT_CONST = 2'd3
  } pattern_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cam_state_t;

  localparam int DEF_H_ACTIVE = 160;
  localparam int DEF_H_BLANK  = 32;
  localparam int DEF_V_ACTIVE = 120;
  localparam int DEF_VS_LINES = 3;
  localparam int DEF_V_BP     = 4;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_AW       = 16;

endpackage

// File: rtl/cam_timing_cnt.sv
// Column/line counters for one camera frame plus vsync/href decode of both the
// current position and the position the next pclk period will show.
module cam_timing_cnt #(
  parameter int H_ACTIVE = 160,
  parameter int H_BLANK  = 32,
  parameter int V_ACTIVE = 120,
  parameter int VS_LINES = 3,
  parameter int V_BP     = 4,
  parameter int V_FP     = 2,
  parameter int CW       = 8,
  parameter int LW       = 8
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [CW-1:0] col_next,
  output logic          frame_last,
  output logic          vsync_now,
  output logic          href_now,
  output logic          vsync_next,
  output logic          href_next
);

  localparam int H_TOTAL   = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL   = VS_LINES + V_BP + V_ACTIVE + V_FP;
  localparam int ACT_FIRST = VS_LINES + V_BP;
  localparam int ACT_END   = ACT_FIRST + V_ACTIVE;

  logic [CW-1:0] col_reg;
  logic [LW-1:0] line_reg;
  logic [LW-1:0] line_next;
  logic          col_last;
  logic          line_last;

  function automatic logic decode_vsync(input logic [LW-1:0] l);
    return l < LW'(VS_LINES);
  endfunction

  function automatic logic decode_href(input logic [CW-1:0] c, input logic [LW-1:0] l);
    return (c < CW'(H_ACTIVE)) && (l >= LW'(ACT_FIRST)) && (l < LW'(ACT_END));
  endfunction

  always_comb begin
    col_last  = (col_reg == CW'(H_TOTAL - 1));
    line_last = (line_reg == LW'(V_TOTAL - 1));
    col_next  = col_last ? '0 : col_reg + CW'(1);
    line_next = line_reg;
    if (col_last) begin
      line_next = line_last ? '0 : line_reg + LW'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      col_reg  <= '0;
      line_reg <= '0;
    end else if (advance) begin
      col_reg  <= col_next;
      line_reg <= line_next;
    end
  end

  assign col        = col_reg;
  assign frame_last = col_last && line_last;
  assign vsync_now  = decode_vsync(line_reg);
  assign href_now   = decode_href(col_reg, line_reg);
  assign vsync_next = decode_vsync(line_next);
  assign href_next  = decode_href(col_next, line_next);

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style pixel bus transmitter: pclk = sysclk/2, vsync/href/d change on pclk
// falling edges, pixel data from a built-in pattern or a 1-cycle-latency frame RAM.
module cam_stream_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VS_LINES = DEF_VS_LINES,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int AW       = DEF_AW
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    pattern_sel,
  input  logic [2:0]    const_val,
  output logic [AW-1:0] rdaddress,
  output logic          rden,
  input  logic [2:0]    q,
  output logic          pclk,
  output logic          vsync,
  output logic          href,
  output logic [2:0]    d,
  output logic          frame_done,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = VS_LINES + V_BP + V_ACTIVE + V_FP;
  // Column is at least 8 bits so the bars pattern can always slice col[7:5].
  localparam int CW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int LW = ($clog2(V_TOTAL) > 1) ? $clog2(V_TOTAL) : 1;

  cam_state_t    state_reg, state_next;
  logic          entry, rise, fall, frame_end, load, stop;
  logic          pclk_reg, vsync_reg, href_reg, frame_done_reg;
  logic [2:0]    d_reg;
  logic [7:0]    frame_count_reg;
  logic [AW-1:0] pix_cnt_reg;
  pattern_t      pat_reg, pat_use;
  logic [CW-1:0] col, col_next, load_col;
  logic          frame_last, vsync_now, href_now, vsync_next, href_next;
  logic          load_vsync, load_href;

  cam_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VS_LINES(VS_LINES), .V_BP(V_BP), .V_FP(V_FP), .CW(CW), .LW(LW)
  ) u_timing (
    .sysclk    (sysclk),
    .reset     (reset),
    .advance   (fall),
    .col       (col),
    .col_next  (col_next),
    .frame_last(frame_last),
    .vsync_now (vsync_now),
    .href_now  (href_now),
    .vsync_next(vsync_next),
    .href_next (href_next)
  );

  function automatic logic [2:0] pixel_of(input pattern_t p, input logic [CW-1:0] c,
                                          input logic [2:0] cv, input logic [2:0] rd);
    case (p)
      PAT_RAMP: return c[2:0];
      PAT_BARS: return c[7:5];
      PAT_RAM:  return rd;
      default:  return cv;
    endcase
  endfunction

  always_ff @(posedge sysclk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    entry      = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    frame_end  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_RUN;
          entry      = 1'b1;
        end
      end
      ST_RUN: begin
        if (pclk_reg) begin
          fall = 1'b1;
          if (frame_last) begin
            frame_end = 1'b1;
            if (!enable) state_next = ST_IDLE;
          end
        end else begin
          rise = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pat_use    = (entry || frame_end) ? pattern_t'(pattern_sel) : pat_reg;
    load       = entry || (fall && (state_next == ST_RUN));
    stop       = fall && (state_next == ST_IDLE);
    load_col   = entry ? col : col_next;
    load_vsync = entry ? vsync_now : vsync_next;
    load_href  = entry ? href_now : href_next;
  end

  // The RAM samples the read on the pclk rising edge; q is then taken into d on the falling edge.
  assign rden      = rise && href_next && (pat_reg == PAT_RAM);
  assign rdaddress = pix_cnt_reg;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pclk_reg        <= 1'b0;
      vsync_reg       <= 1'b0;
      href_reg        <= 1'b0;
      d_reg           <= 3'd0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= 8'd0;
      pix_cnt_reg     <= '0;
      pat_reg         <= PAT_RAMP;
    end else begin
      frame_done_reg <= frame_end;
      if (frame_end) frame_count_reg <= frame_count_reg + 8'd1;
      if (rise)      pclk_reg <= 1'b1;
      else if (fall) pclk_reg <= 1'b0;
      // The read address is the running count of active pixels in this frame.
      if (entry || frame_end) begin
        pat_reg     <= pat_use;
        pix_cnt_reg <= '0;
      end else if (rden) begin
        pix_cnt_reg <= pix_cnt_reg + AW'(1);
      end
      if (load) begin
        vsync_reg <= load_vsync;
        href_reg  <= load_href;
        d_reg     <= load_href ? pixel_of(pat_use, load_col, const_val, q) : 3'd0;
      end else if (stop) begin
        vsync_reg <= 1'b0;
        href_reg  <= 1'b0;
        d_reg     <= 3'd0;
      end
    end
  end

  assign pclk        = pclk_reg;
  assign vsync       = vsync_reg;
  assign href        = href_reg;
  assign d           = d_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Randomized bench for cam_stream_gen with small timing; a frame-position reference
// model derived from elapsed sysclk cycles predicts every output on every cycle.
module tb_cam_stream_gen;

  localparam int HA  = 8;
  localparam int HB  = 4;
  localparam int VA  = 3;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int AW  = 16;
  localparam int HT  = HA + HB;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int ACT0 = VS + VBP;
  localparam int FRAME_CYC = 2 * HT * VT;

  logic          sysclk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic [2:0]    const_val = 3'd0;
  logic [AW-1:0] rdaddress;
  logic          rden;
  logic [2:0]    q;
  logic          pclk, vsync, href, frame_done;
  logic [2:0]    d;
  logic [7:0]    frame_count;
  logic [2:0]    mem [0:31];

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit         m_run = 0;
  int         m_t = 0;
  int         m_fc = 0;
  bit         m_done = 0;
  int         m_pat = 0;
  logic [2:0] m_d = 3'd0;

  cam_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VS_LINES(VS), .V_BP(VBP), .V_FP(VFP), .AW(AW)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .const_val  (const_val),
    .rdaddress  (rdaddress),
    .rden       (rden),
    .q          (q),
    .pclk       (pclk),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (rden) q <= mem[rdaddress[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic bit is_active(input int p);
    int ln;
    int cl;
    ln = p / HT;
    cl = p % HT;
    return (cl < HA) && (ln >= ACT0) && (ln < ACT0 + VA);
  endfunction

  task automatic load_pixel();
    int p;
    int ln;
    int cl;
    p  = m_t / 2;
    ln = p / HT;
    cl = p % HT;
    if (!is_active(p))   m_d = 3'd0;
    else if (m_pat == 0) m_d = 3'(cl % 8);
    else if (m_pat == 1) m_d = 3'((cl / 32) % 8);
    else if (m_pat == 2) m_d = mem[(ln - ACT0) * HA + cl];
    else                 m_d = const_val;
  endtask

  task automatic model_step();
    m_done = 0;
    if (reset) begin
      m_run = 0; m_t = 0; m_fc = 0; m_d = 3'd0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1; m_t = 0; m_pat = int'(pattern_sel);
        load_pixel();
      end
    end else begin
      m_t++;
      if (m_t == FRAME_CYC) begin
        m_done = 1;
        m_fc = (m_fc + 1) % 256;
        m_t = 0;
        if (!enable) begin
          m_run = 0; m_d = 3'd0;
        end else begin
          m_pat = int'(pattern_sel);
        end
      end
      if (m_run && (m_t % 2 == 0)) load_pixel();
    end
  endtask

  task automatic tick();
    int p;
    int np;
    bit e_rden;
    @(posedge sysclk);
    model_step();
    #1;
    p  = m_t / 2;
    np = (p + 1) % (HT * VT);
    e_rden = m_run && (m_t % 2 == 0) && (m_pat == 2) && is_active(np);
    check("pclk", 32'(pclk), m_run ? 32'(m_t % 2) : 32'd0);
    check("vsync", 32'(vsync), 32'(m_run && (p / HT) < VS));
    check("href", 32'(href), 32'(m_run && is_active(p)));
    check("d", 32'(d), 32'(m_d));
    check("rden", 32'(rden), 32'(e_rden));
    if (e_rden) check("rdaddress", 32'(rdaddress), 32'(((np / HT) - ACT0) * HA + np % HT));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    if (m_done) $display("frame done: count=%0d pattern=%0d t=%0t", m_fc, m_pat, $time);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 3'(i) ^ 3'd3;
    q = 3'd0;

    // reset, then continuous ramp
    run_cycles(3);
    reset = 1'b0;
    run_cycles(2);
    enable = 1'b1;
    pattern_sel = 2'd0;
    run_cycles(3 * FRAME_CYC + 5);

    // RAM pattern, latched at the next frame start
    pattern_sel = 2'd2;
    run_cycles(2 * FRAME_CYC);

    // drop enable 50 cycles into a frame; frame completes, then idle
    for (int i = 0; i < 2 * FRAME_CYC && m_t != 50; i++) tick();
    enable = 1'b0;
    run_cycles(FRAME_CYC + 40);
    // restart with constant pattern, switch to ramp mid-frame
    pattern_sel = 2'd3;
    const_val = 3'd5;
    enable = 1'b1;
    run_cycles(60);
    pattern_sel = 2'd0;
    run_cycles(FRAME_CYC + 20);

    // reset in the middle of an active line
    for (int i = 0; i < 2 * FRAME_CYC && !(m_run && is_active(m_t / 2) && (m_t / 2) % HT == 3); i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_cycles(10);

    // 256+ frames with random RAM contents and random pattern/const changes
    for (int i = 0; i < 32; i++) mem[i] = 3'($urandom);
    for (int i = 0; i < 257 * FRAME_CYC; i++) begin
      if ($urandom_range(0, 15) == 0) pattern_sel = 2'($urandom);
      if ($urandom_range(0, 15) == 0) const_val = 3'($urandom);
      tick();
    end

    // random enable toggling
    for (int k = 0; k < 40; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      pattern_sel = 2'($urandom);
      const_val = 3'($urandom);
      run_cycles($urandom_range(20, 200));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
